// File: rtl/cordic_iter_param.sv
// Iterative CORDIC: rotation/vectoring on one request at a time, ITER micro-rotations per request.
// Latency ITER+1 clocks accept->out_valid; in_ready only when idle, result held until out_ready.
module cordic_iter_param #(
  parameter int DW   = 16,
  parameter int AW   = 16,
  parameter int ITER = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  input  logic signed [AW-1:0] z_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW+1:0] x_out,
  output logic signed [DW+1:0] y_out,
  output logic signed [AW-1:0] z_out
);

  localparam int W  = DW + 2;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic signed [AW-1:0] QTR = {2'b01, {(AW-2){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]  x_q, y_q;
  logic signed [AW-1:0] z_q;
  logic                 mode_q;
  logic [CW-1:0]        i_q;
  logic                 last_iter;

  logic signed [W-1:0]  x_pre, y_pre, x_it, y_it, x_sh, y_sh;
  logic signed [AW-1:0] z_pre, z_it, a_i;
  logic                 dir_pos;

  // atan(2^-i) with +-pi mapped to +-2^31, rescaled to AW bits with rounding.
  function automatic logic signed [AW-1:0] atan_entry(input logic [CW-1:0] idx);
    longint v;
    int     sh;
    case (int'(idx))
      0:       v = 64'd536870912;
      1:       v = 64'd316933406;
      2:       v = 64'd167458907;
      3:       v = 64'd85004756;
      4:       v = 64'd42667331;
      5:       v = 64'd21354465;
      6:       v = 64'd10679838;
      7:       v = 64'd5340245;
      8:       v = 64'd2670163;
      9:       v = 64'd1335087;
      10:      v = 64'd667544;
      11:      v = 64'd333772;
      12:      v = 64'd166886;
      13:      v = 64'd83443;
      14:      v = 64'd41722;
      15:      v = 64'd20861;
      16:      v = 64'd10430;
      17:      v = 64'd5215;
      18:      v = 64'd2608;
      19:      v = 64'd1304;
      20:      v = 64'd652;
      21:      v = 64'd326;
      22:      v = 64'd163;
      23:      v = 64'd81;
      24:      v = 64'd41;
      25:      v = 64'd20;
      26:      v = 64'd10;
      27:      v = 64'd5;
      28:      v = 64'd3;
      29:      v = 64'd1;
      30:      v = 64'd1;
      default: v = 64'd0;
    endcase
    sh = 32 - AW;
    if (sh > 0)
      v = (v + (longint'(1) << (sh - 1))) >>> sh;
    else if (sh < 0)
      v = v << (-sh);
    return AW'(v);
  endfunction

  assign last_iter = (i_q == CW'(ITER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_PRE;
      end
      S_PRE:  state_d = S_ITER;
      S_ITER: if (last_iter) state_d = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Quarter-turn pre-rotation so the micro-rotations only need to cover +-90 degrees.
  always_comb begin
    x_pre = x_q;
    y_pre = y_q;
    z_pre = z_q;
    if (!mode_q) begin
      if (z_q >= QTR) begin
        x_pre = -y_q;
        y_pre = x_q;
        z_pre = z_q - QTR;
      end else if (z_q < -QTR) begin
        x_pre = y_q;
        y_pre = -x_q;
        z_pre = z_q + QTR;
      end
    end else if (x_q < 0) begin
      if (y_q >= 0) begin
        x_pre = y_q;
        y_pre = -x_q;
        z_pre = z_q + QTR;
      end else begin
        x_pre = -y_q;
        y_pre = x_q;
        z_pre = z_q - QTR;
      end
    end
  end

  always_comb begin
    a_i     = atan_entry(i_q);
    x_sh    = x_q >>> i_q;
    y_sh    = y_q >>> i_q;
    dir_pos = mode_q ? y_q[W-1] : ~z_q[AW-1];
    if (dir_pos) begin
      x_it = x_q - y_sh;
      y_it = y_q + x_sh;
      z_it = z_q - a_i;
    end else begin
      x_it = x_q + y_sh;
      y_it = y_q - x_sh;
      z_it = z_q + a_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      mode_q <= 1'b0;
      i_q    <= '0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q    <= {{2{x_in[DW-1]}}, x_in};
            y_q    <= {{2{y_in[DW-1]}}, y_in};
            z_q    <= z_in;
            mode_q <= mode;
          end
        end
        S_PRE: begin
          x_q <= x_pre;
          y_q <= y_pre;
          z_q <= z_pre;
          i_q <= '0;
        end
        S_ITER: begin
          x_q <= x_it;
          y_q <= y_it;
          z_q <= z_it;
          if (last_iter) begin
            i_q   <= '0;
            x_out <= x_it;
            y_out <= y_it;
            z_out <= z_it;
          end else begin
            i_q <= i_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_param.sv
// Randomized + directed bench for cordic_iter_param; scoreboard fed by an arithmetic reference model.
module tb_cordic_iter_param;
  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int ITER = 14;
  localparam int W    = DW + 2;

  typedef struct packed {
    logic signed [W-1:0]  x;
    logic signed [W-1:0]  y;
    logic signed [AW-1:0] z;
  } res_t;

  logic                 clk, rst, in_valid, in_ready, mode, out_valid, out_ready;
  logic signed [DW-1:0] x_in, y_in;
  logic signed [AW-1:0] z_in;
  logic signed [W-1:0]  x_out, y_out;
  logic signed [AW-1:0] z_out;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  res_t e_mon, e_tmp, got;

  cordic_iter_param #(.DW(DW), .AW(AW), .ITER(ITER)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: quarter-turn fold, then ITER micro-rotations with angles from real atan.
  function automatic res_t model(input bit m, input logic signed [DW-1:0] xi,
                                 input logic signed [DW-1:0] yi, input logic signed [AW-1:0] zi);
    logic signed [W-1:0]  x, y, xn, yn;
    logic signed [AW-1:0] z, q, a;
    real pi, ang;
    res_t r;
    pi = 4.0 * $atan(1.0);
    q  = AW'(longint'(1) << (AW - 2));
    x  = {{2{xi[DW-1]}}, xi};
    y  = {{2{yi[DW-1]}}, yi};
    z  = zi;
    if (!m) begin
      if (z >= q)       begin xn = -y; y = x;  x = xn; z = z - q; end
      else if (z < -q)  begin xn = y;  y = -x; x = xn; z = z + q; end
    end else if (x < 0) begin
      if (y >= 0) begin xn = y;  y = -x; x = xn; z = z + q; end
      else        begin xn = -y; y = x;  x = xn; z = z - q; end
    end
    for (int i = 0; i < ITER; i++) begin
      ang = $atan(2.0 ** (-i)) / pi * (2.0 ** (AW - 1));
      a   = AW'($rtoi(ang + 0.5));
      if ((m && y < 0) || (!m && z >= 0)) begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - a;
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + a;
      end
      x = xn;
      y = yn;
    end
    r.x = x; r.y = y; r.z = z;
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tol(input string name, input longint act, input longint tgt, input longint t);
    checks++;
    if (act < tgt - t || act > tgt + t) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d+-%0d", name, act, tgt, t);
    end
  endtask

  task automatic ztol(input string name, input logic signed [AW-1:0] act,
                      input logic signed [AW-1:0] tgt, input longint t);
    logic signed [AW-1:0] d;
    d = act - tgt;
    tol(name, d, 0, t);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected x=%0d y=%0d z=%0d with no request pending", x_out, y_out, z_out);
      end else begin
        e_mon = sb.pop_front();
        if (x_out !== e_mon.x || y_out !== e_mon.y || z_out !== e_mon.z) begin
          errors++;
          $display("FAIL mon_result actual=(%0d,%0d,%0d) expected=(%0d,%0d,%0d)",
                   x_out, y_out, z_out, e_mon.x, e_mon.y, e_mon.z);
        end
      end
    end
  end

  task automatic run_req(input bit m, input logic signed [DW-1:0] xi, input logic signed [DW-1:0] yi,
                         input logic signed [AW-1:0] zi, input int hold, output res_t cap);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("wait_in_ready", in_ready, 1);
    out_ready = (hold == 0);
    mode = m; x_in = xi; y_in = yi; z_in = zi; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(m, xi, yi, zi));
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("latency", n, ITER + 1);
    cap.x = x_out; cap.y = y_out; cap.z = z_out;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_stable", (x_out == cap.x && y_out == cap.y && z_out == cap.z), 1);
    end
    if (hold > 0) out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_keep", (x_out == cap.x && y_out == cap.y && z_out == cap.z), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs_zero", (x_out == 0 && y_out == 0 && z_out == 0), 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_req(1'b0, 16'sd9949, 16'sd0, 16'sh2000, 0, got);
    tol("rot45_x", got.x, 11585, 4);
    tol("rot45_y", got.y, 11585, 4);
    ztol("rot45_z", got.z, 16'sh0000, 8);

    run_req(1'b0, 16'sd9949, 16'sd0, 16'sh6000, 0, got);
    tol("rot135_x", got.x, -11585, 4);
    tol("rot135_y", got.y, 11585, 4);

    run_req(1'b1, -16'sd16384, 16'sd0, 16'sh0000, 0, got);
    tol("vec_x", got.x, 26981, 4);
    tol("vec_y", got.y, 0, 4);
    ztol("vec_z", got.z, 16'sh8000, 8);

    run_req(1'b0, 16'sd9949, 16'sd0, 16'sh2000, 5, got);

    // Reset six clocks into an operation: result must vanish, bench drops its expectation.
    while (!in_ready) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    mode = 1'b0; x_in = 16'sd5000; y_in = -16'sd3000; z_in = 16'sh1234; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(1'b0, 16'sd5000, -16'sd3000, 16'sh1234));
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outputs_zero", (x_out == 0 && y_out == 0 && z_out == 0), 1);
    e_tmp = sb.pop_back();
    @(negedge clk) rst = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      chk("midrst_no_valid", seen, 0);
    end
    run_req(1'b1, 16'sd8000, 16'sd8000, 16'sh0000, 0, got);

    run_req(1'b0, -16'sd32768, 16'sd32767, 16'sh7fff, 1, got);
    run_req(1'b1, -16'sd32768, -16'sd32768, 16'sh8000, 2, got);
    run_req(1'b0, 16'sd32767, -16'sd32768, 16'sh8000, 0, got);
    run_req(1'b0, 16'sd12345, 16'sd0, 16'shc000, 0, got);

    for (int k = 0; k < 40; k++) begin
      run_req(1'($urandom), DW'($urandom), DW'($urandom), AW'($urandom),
              int'($urandom_range(0, 3)), got);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_iter_param.md
CORDIC_ITER_PARAM -- requirements
Module: cordic_iter_param

Interface
REQ-001 SHALL have parameter DW, default 16: signed width of x_in/y_in, Q2.(DW-2) format (1.0 = 2^(DW-2)).
REQ-002 SHALL have parameter AW, default 16: signed binary-angle width; full scale ±pi maps to ±2^(AW-1).
REQ-003 SHALL have parameter ITER, default 14: number of micro-rotations; legal range 1..min(AW-1, DW+1).
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port mode  input  1  0 = rotation, 1 = vectoring; sampled at acceptance.
REQ-009 SHALL have ports x_in and y_in  input  DW  signed vector.
REQ-010 SHALL have port z_in  input  AW  signed angle.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have ports x_out and y_out  output  DW+2  signed result, same fraction bits as input, CORDIC gain K≈1.6468 not compensated.
REQ-014 SHALL have port z_out  output  AW  signed residual (rotation) or accumulated angle (vectoring).

Function
REQ-015 SHALL implement FSM IDLE -> PRE -> ITER -> DONE -> IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept a request on the edge where in_valid && in_ready; sign-extend x_in/y_in to DW+2; latch z_in and mode; go to PRE.
REQ-018 PRE (1 cycle), rotation mode: if z >= 2^(AW-2) then (x,y,z) <- (-y, x, z-2^(AW-2)); if z < -2^(AW-2) then (x,y,z) <- (y, -x, z+2^(AW-2)); else unchanged.
REQ-019 PRE, vectoring mode: if x < 0 and y >= 0 then (x,y,z) <- (y, -x, z+2^(AW-2)); if x < 0 and y < 0 then (x,y,z) <- (-y, x, z-2^(AW-2)); else unchanged.
REQ-020 ITER SHALL run a counter i = 0..ITER-1, one micro-rotation per clock, then enter DONE.
REQ-021 Each micro-rotation SHALL compute x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*A[i], all from pre-update values.
REQ-022 Direction d: rotation mode d = +1 if z >= 0, else -1; vectoring mode d = +1 if y < 0, else -1.
REQ-023 A[i] SHALL equal round(atan(2^-i)/pi * 2^(AW-1)), held in a constant table of at least ITER entries.
REQ-024 >>> SHALL be arithmetic shift; z arithmetic SHALL wrap modulo 2^AW; x/y SHALL use DW+2 bits without saturation.
REQ-025 out_valid SHALL rise exactly ITER+1 clocks after the acceptance edge (1 PRE + ITER iterations).
REQ-026 In DONE, out_valid = 1 and x_out/y_out/z_out SHALL hold stable until out_valid && out_ready; the FSM then returns to IDLE.
REQ-027 x_out/y_out/z_out SHALL keep the last result after the output handshake, until the next result is written.
REQ-028 There SHALL be no pipelining: at most one request in flight.

Reset
REQ-029 rst SHALL asynchronously force IDLE, i = 0, and all datapath registers and outputs to 0; in_ready is then 1 and out_valid 0.
REQ-030 rst during PRE/ITER/DONE SHALL discard the in-flight result; out_valid SHALL NOT assert for it.

Verification (DW=16, AW=16, ITER=14)
REQ-031 Rotation: x_in=9949, y_in=0, z_in=0x2000 (45 deg) -> x_out≈y_out≈11585 ±4, z_out within ±8 of 0.
REQ-032 Quadrant: x_in=9949, y_in=0, z_in=0x6000 (135 deg) -> x_out≈-11585, y_out≈11585 ±4.
REQ-033 Vectoring: x_in=-16384, y_in=0, z_in=0 -> x_out≈26981 ±4, |y_out| ≤ 4, z_out within ±8 LSB of 0x8000 modulo 2^16.
REQ-034 Timing/backpressure: hold out_ready=1 -> out_valid exactly 15 clocks after accept. Hold out_ready=0 for 5 extra clocks -> out_valid stays 1, outputs stable, in_ready stays 0.
REQ-035 Reset mid-op: assert rst 6 clocks after accept -> immediate IDLE, all outputs 0, no out_valid. A new request then completes normally.
